// File: rtl/uart_pkg.sv
// Shared state encoding, parity codes and STATUS bit positions for uart_tx_fifo.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam logic [1:0] PAR_NONE     = 2'b00;
  localparam logic [1:0] PAR_EVEN     = 2'b01;
  localparam logic [1:0] PAR_ODD      = 2'b10;
  localparam logic [1:0] PAR_NONE_ALT = 2'b11;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_LEVEL_LSB = 4;

  // The STATUS level field is only four bits wide, so larger counts pin at 15.
  function automatic logic [3:0] sat_level(input int n);
    return (n > 15) ? 4'd15 : 4'(n);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with level tracking and push-while-full overflow detection.
// The *_next outputs describe the state after the current edge so the parent can register them.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    clr_ovf,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level_next,
  output logic                    full_next,
  output logic                    empty_next,
  output logic                    ovf_next
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             full, ovf_q, do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // A push into a full FIFO is dropped even when a pop frees a slot that same cycle.
  assign level_next = count + CW'(do_push) - CW'(do_pop);
  assign full_next  = (level_next == CW'(DEPTH));
  assign empty_next = (level_next == '0);
  assign ovf_next   = (push & full) | (ovf_q & ~clr_ovf);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= level_next;
      ovf_q <= ovf_next;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by an internal FIFO; frames go out back-to-back on LINE_OUT.
// Optional line-break support is enabled with the UART_TX_BREAK_EN macro.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int STOP_BITS = 1
) (
  input  logic              CLK,
  input  logic              RST,
`ifdef UART_TX_BREAK_EN
  input  logic              BREAK,
`endif
  input  logic [DATA_W-1:0] DATA,
  input  logic              WR,
  input  logic [15:0]       BAUD_DIV,
  input  logic [1:0]        PARITY_MODE,
  input  logic              CLR_OVF,
  output logic [7:0]        STATUS,
  output logic              LINE_OUT
);
  localparam int CW = $clog2(DEPTH) + 1;

  tx_state_t         state, state_n;
  logic [15:0]       timer, timer_n, div_q, div_n, baud_eff;
  logic [3:0]        bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] shift, shift_n, fifo_dout;
  logic              par_en, par_en_n, par_bit, par_bit_n;
  logic              pop, hold, brk_active, brk_busy_n, last_stop;
  logic              fifo_empty, fifo_full_n, fifo_empty_n, fifo_ovf_n;
  logic [CW-1:0]     fifo_level_n;
  logic [7:0]        status_q, status_n;

  assign baud_eff  = (BAUD_DIV == 16'd0) ? 16'd1 : BAUD_DIV;
  assign last_stop = (state == ST_STOP) && (timer == 16'd1) && (bit_cnt == 4'(STOP_BITS - 1));

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk        (CLK),
    .rst        (RST),
    .push       (WR),
    .pop        (pop),
    .clr_ovf    (CLR_OVF),
    .din        (DATA),
    .dout       (fifo_dout),
    .empty      (fifo_empty),
    .level_next (fifo_level_n),
    .full_next  (fifo_full_n),
    .empty_next (fifo_empty_n),
    .ovf_next   (fifo_ovf_n)
  );

  // Frame sequencing; divisor and parity mode are captured at pop so mid-frame changes wait.
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    div_n     = div_q;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_en_n  = par_en;
    par_bit_n = par_bit;
    pop       = 1'b0;
    if (state == ST_IDLE || last_stop) begin
      if (last_stop) begin
        state_n   = ST_IDLE;
        timer_n   = '0;
        bit_cnt_n = '0;
      end
      if (!fifo_empty && !hold) begin
        pop       = 1'b1;
        state_n   = ST_START;
        shift_n   = fifo_dout;
        div_n     = baud_eff;
        timer_n   = baud_eff;
        bit_cnt_n = '0;
        par_en_n  = (PARITY_MODE == PAR_EVEN) || (PARITY_MODE == PAR_ODD);
        par_bit_n = (^fifo_dout) ^ (PARITY_MODE == PAR_ODD);
      end
    end else if (timer != 16'd1) begin
      timer_n = timer - 16'd1;
    end else begin
      timer_n = div_q;
      case (state)
        ST_START: begin
          state_n   = ST_DATA;
          bit_cnt_n = '0;
        end
        ST_DATA: begin
          shift_n = shift >> 1;
          if (bit_cnt == 4'(DATA_W - 1)) begin
            bit_cnt_n = '0;
            state_n   = par_en ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end
        ST_PARITY: begin
          state_n   = ST_STOP;
          bit_cnt_n = '0;
        end
        ST_STOP:  bit_cnt_n = bit_cnt + 4'd1;
        default:  state_n = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    LINE_OUT = 1'b1;
    case (state)
      ST_IDLE:   LINE_OUT = ~brk_active;
      ST_START:  LINE_OUT = 1'b0;
      ST_DATA:   LINE_OUT = shift[0];
      ST_PARITY: LINE_OUT = par_bit;
      default:   LINE_OUT = 1'b1;
    endcase
  end

  // STATUS is built from next-cycle values so the register lines up with the state it reports.
  always_comb begin
    status_n = '0;
    status_n[STAT_BUSY]  = (state_n != ST_IDLE) | brk_busy_n;
    status_n[STAT_FULL]  = fifo_full_n;
    status_n[STAT_EMPTY] = fifo_empty_n;
    status_n[STAT_OVF]   = fifo_ovf_n;
    status_n[STAT_LEVEL_LSB +: 4] = sat_level(int'(fifo_level_n));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      timer    <= '0;
      div_q    <= 16'd1;
      bit_cnt  <= '0;
      shift    <= '0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      status_q <= 8'b0000_0100;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      div_q    <= div_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      par_en   <= par_en_n;
      par_bit  <= par_bit_n;
      status_q <= status_n;
    end
  end

  assign STATUS = status_q;

`ifdef UART_TX_BREAK_EN
  logic        brk_active_n;
  logic [15:0] guard, guard_n;

  // After a break is released the line idles high for a full bit time before any start bit.
  always_comb begin
    brk_active_n = brk_active;
    guard_n      = guard;
    if (guard != 16'd0) guard_n = guard - 16'd1;
    if (brk_active && !BREAK) begin
      brk_active_n = 1'b0;
      guard_n      = baud_eff;
    end else if (BREAK && state == ST_IDLE) begin
      brk_active_n = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      brk_active <= 1'b0;
      guard      <= '0;
    end else begin
      brk_active <= brk_active_n;
      guard      <= guard_n;
    end
  end

  assign hold       = BREAK | brk_active | (guard != 16'd0);
  assign brk_busy_n = brk_active_n;
`else
  assign brk_active = 1'b0;
  assign hold       = 1'b0;
  assign brk_busy_n = 1'b0;
`endif

endmodule
